// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and a
// full-precision reference computation of {bout, diff}.
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reference {bout, diff} for x - y - bin at the given width (2..32).
    // The result is packed as bit 32 = bout, bits 31:0 = diff.
    function automatic logic [32:0] sub_ref(input int unsigned width,
                                            input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic        bin);
        logic [63:0] mask;
        logic [63:0] xm;
        logic [63:0] ym;
        logic [63:0] full;
        logic        b;
        mask = (64'd1 << width) - 64'd1;
        xm   = {32'd0, x} & mask;
        ym   = {32'd0, y} & mask;
        full = xm - ym - {63'd0, bin};
        b    = (xm < (ym + {63'd0, bin}));
        return {b, full[31:0] & mask[31:0]};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, x, y, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, x, y, bin,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor_1bit (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);
    logic na;
    logic t0;
    logic t1;
    logic t2;

    assign na = ~a;
    assign t0 = na & b;
    assign t1 = na & bi;
    assign t2 = b & bi;
    assign d  = a ^ b ^ bi;
    assign bo = t0 | t1 | t2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB first, one bit per clock, and publishes {bout, diff, zero} on completion.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;

    logic             d_bit;
    logic             bo_bit;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] res_next;

    full_subtractor_1bit u_cell (
        .d  (d_bit),
        .bo (bo_bit),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (br_q)
    );

    // The bit being computed this cycle is the last one when the counter
    // has reached WIDTH-1; the result register then already holds the rest.
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    // Control FSM: IDLE -> RUN for WIDTH cycles -> DONE for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) state <= ST_RUN;
                ST_RUN:  if (last_bit)  state <= ST_DONE;
                ST_DONE: state <= bus.start ? ST_RUN : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand/result shift registers, running borrow and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br_q   <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= bus.x;
            b_sr   <= bus.y;
            res_sr <= '0;
            br_q   <= bus.bin;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            br_q   <= bo_bit;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result registers update only when the final bit is produced, so they
    // stay stable during RUN and hold the last result while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if ((state == ST_RUN) && last_bit) begin
            diff_q <= res_next;
            bout_q <= bo_bit;
            zero_q <= (res_next == '0);
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 2, 4 and 8 against an arithmetic model.
module tb_serial_subtractor;
    import sub_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         sel = 2;
    logic       go = 1'b0;
    logic [7:0] xr = 8'd0;
    logic [7:0] yr = 8'd0;
    logic       br = 1'b0;

    logic       o_busy;
    logic       o_done;
    logic [7:0] o_diff;
    logic       o_bout;
    logic       o_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(2)) if2 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

    serial_subtractor #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    assign if2.start = go && (sel == 2);
    assign if2.x     = xr[1:0];
    assign if2.y     = yr[1:0];
    assign if2.bin   = br;
    assign if4.start = go && (sel == 4);
    assign if4.x     = xr[3:0];
    assign if4.y     = yr[3:0];
    assign if4.bin   = br;
    assign if8.start = go && (sel == 8);
    assign if8.x     = xr;
    assign if8.y     = yr;
    assign if8.bin   = br;

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_diff = 8'd0;
        o_bout = 1'b0;
        o_zero = 1'b0;
        case (sel)
            2: begin
                o_busy = if2.busy; o_done = if2.done; o_diff = {6'd0, if2.diff};
                o_bout = if2.bout; o_zero = if2.zero;
            end
            4: begin
                o_busy = if4.busy; o_done = if4.done; o_diff = {4'd0, if4.diff};
                o_bout = if4.bout; o_zero = if4.zero;
            end
            default: begin
                o_busy = if8.busy; o_done = if8.done; o_diff = if8.diff;
                o_bout = if8.bout; o_zero = if8.zero;
            end
        endcase
    end

    // {bout, diff} from plain unsigned arithmetic at the selected width.
    function automatic logic [8:0] model(input int w, input logic [7:0] xv,
                                         input logic [7:0] yv, input logic bv);
        int unsigned m;
        int unsigned xi;
        int unsigned yi;
        int unsigned bi;
        int unsigned d;
        m  = (32'd1 << w) - 32'd1;
        xi = 32'(xv) & m;
        yi = 32'(yv) & m;
        bi = 32'(bv);
        d  = (xi - yi - bi) & m;
        return {(xi < (yi + bi)), d[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation (start asserted for the next edge) and follow it to
    // done. A nonzero poke re-pulses start with other operands mid-RUN.
    task automatic do_op(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                         input string tag, input int poke);
        logic [8:0] exp;
        logic [7:0] prev_diff;
        int         lat;
        bit         seen;
        exp       = model(sel, xv, yv, bv);
        prev_diff = o_diff;
        xr = xv; yr = yv; br = bv; go = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            go = 1'b0;
            if (lat == poke) begin
                xr = ~xv; yr = xv; br = ~bv; go = 1'b1;
            end
            if (o_done) seen = 1;
            else begin
                check({tag, "/busy"}, 32'(o_busy), 32'd1);
                check({tag, "/hold"}, 32'(o_diff), 32'(prev_diff));
            end
        end
        go = 1'b0;
        vectors++;
        check({tag, "/latency"}, 32'(lat), 32'(sel + 1));
        check({tag, "/diff"}, 32'(o_diff), 32'(exp[7:0]));
        check({tag, "/bout"}, 32'(o_bout), 32'(exp[8]));
        check({tag, "/zero"}, 32'(o_zero), 32'(exp[7:0] == 8'd0));
        check({tag, "/busy_done"}, 32'(o_busy), 32'd0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        check({tag, "/done_gone"}, 32'(o_done), 32'd0);
        check({tag, "/busy_gone"}, 32'(o_busy), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/busy"}, 32'(o_busy), 32'd0);
        check({tag, "/done"}, 32'(o_done), 32'd0);
        check({tag, "/diff"}, 32'(o_diff), 32'd0);
        check({tag, "/bout"}, 32'(o_bout), 32'd0);
        check({tag, "/zero"}, 32'(o_zero), 32'd0);
    endtask

    initial begin
        logic [32:0] r;
        logic [8:0]  m;
        logic [7:0]  rx;
        logic [7:0]  ry;
        logic        rb;

        // Reset state of all three widths.
        repeat (2) @(posedge clk);
        #1;
        sel = 2; #1; check_cleared("rst_w2");
        sel = 4; #1; check_cleared("rst_w4");
        sel = 8; #1; check_cleared("rst_w8");
        rst_n = 1'b1;
        sel = 2;
        @(posedge clk); #1;

        // WIDTH=2 directed cases.
        do_op(8'h3, 8'h3, 1'b1, "w2_eq_bin1", 0);
        check("w2_eq_bin1/const", 32'(o_diff), 32'h3);
        idle_cycle("w2_after1");
        do_op(8'h0, 8'h0, 1'b0, "w2_zero_a", 0);
        idle_cycle("w2_after2");
        do_op(8'h2, 8'h1, 1'b1, "w2_zero_b", 0);
        check("w2_zero_b/zconst", 32'(o_zero), 32'd1);
        idle_cycle("w2_after3");
        do_op(8'h0, 8'h3, 1'b0, "w2_b2b_a", 0);
        do_op(8'h1, 8'h1, 1'b1, "w2_b2b_b", 0);
        check("w2_b2b_b/const", 32'(o_diff), 32'h3);
        idle_cycle("w2_after4");

        // WIDTH=8: start pulsed mid-RUN must be ignored, single done pulse.
        sel = 8; #1;
        do_op(8'h00, 8'h01, 1'b0, "w8_ignore", 2);
        check("w8_ignore/const", 32'(o_diff), 32'hFF);
        idle_cycle("w8_single_done");

        // WIDTH=8: reset in the third RUN cycle aborts the operation.
        xr = 8'hA5; yr = 8'h3C; br = 1'b0; go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_cleared("w8_abort");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("w8_abort/no_done", 32'(o_done), 32'd0);
        end
        do_op(8'hA5, 8'h3C, 1'b0, "w8_fresh", 0);
        check("w8_fresh/const", 32'(o_diff), 32'h69);
        idle_cycle("w8_after_fresh");

        // WIDTH=4 exhaustive sweep, back-to-back, plus package reference check.
        sel = 4; #1;
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    do_op(8'(xi), 8'(yi), 1'(bi), "w4_sweep", 0);
                    r = sub_ref(4, 32'(xi), 32'(yi), 1'(bi));
                    m = model(4, 8'(xi), 8'(yi), 1'(bi));
                    check("w4_pkg_ref/diff", r[31:0], 32'(m[7:0]));
                    check("w4_pkg_ref/bout", 32'(r[32]), 32'(m[8]));
                end
            end
        end
        idle_cycle("w4_after_sweep");

        // WIDTH=8 randomized operations with random idle gaps and edge cases.
        sel = 8; #1;
        for (int i = 0; i < 40; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 1'($urandom);
            if (i % 10 == 3) begin ry = rx; rb = 1'b1; end
            if (i % 10 == 7) begin ry = 8'd0; rb = 1'b0; end
            do_op(rx, ry, rb, "w8_rand", 0);
            if ($urandom_range(0, 1) == 1) idle_cycle("w8_rand_gap");
        end
        idle_cycle("w8_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
